// File: rtl/fifo_wr_sched.sv
// Write/read scheduler in front of a single-enable sync FIFO (en=1 write, en=0 read).
// Turns a valid/ready producer stream into FIFO writes, interleaves forced reads, and rebuilds a valid-qualified pop stream.
module fifo_wr_sched #(
  parameter int DATA_WIDTH = 5,
  parameter int FIFO_DEPTH = 8,
  parameter int WR_BURST   = 4,
  parameter int AF_THRESH  = 6
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            s_valid,
  input  logic [DATA_WIDTH-1:0]           s_data,
  output logic                            s_ready,
  input  logic                            flush,
  output logic                            fifo_en,
  output logic [DATA_WIDTH-1:0]           fifo_data_in,
  input  logic                            fifo_full,
  input  logic                            fifo_empty,
  input  logic [DATA_WIDTH-1:0]           fifo_data_out,
  output logic                            m_valid,
  output logic [DATA_WIDTH-1:0]           m_data,
  output logic [$clog2(FIFO_DEPTH):0]     level,
  output logic                            almost_full,
  output logic                            flushing,
  output logic                            err_level
);

  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  localparam int BW = $clog2(WR_BURST + 1);

  localparam logic [LW-1:0] LEVEL_MAX = LW'(FIFO_DEPTH);
  localparam logic [LW-1:0] LEVEL_AF  = LW'(AF_THRESH);
  localparam logic [BW-1:0] BURST_MAX = BW'(WR_BURST);

  // Handshake: a beat transfers on a rising edge where s_valid && s_ready;
  // s_ready never depends on s_valid, and m_valid beats cannot be stalled.

  typedef enum logic {
    FL_IDLE  = 1'b0,
    FL_DRAIN = 1'b1
  } flush_state_t;

  flush_state_t   fl_state, fl_state_nxt;
  logic [BW-1:0]  burst_cnt, burst_cnt_nxt;
  logic [LW-1:0]  level_q, level_nxt;
  logic           m_valid_q;
  logic           err_q, err_nxt;

  logic           force_rd;
  logic           wr_go;
  logic           rd_go;
  logic           drain_done;
  logic           level_mismatch;

  // ---------------------------------------------------------------------------
  // Per-cycle decode
  // ---------------------------------------------------------------------------
  always_comb begin
    force_rd     = (burst_cnt == BURST_MAX) && !fifo_empty;
    s_ready      = rst_n && !fifo_full && (fl_state == FL_IDLE) && !force_rd;
    wr_go        = s_valid && s_ready;
    fifo_en      = wr_go;
    fifo_data_in = s_data;
    // Whenever no write is issued the FIFO pops, so data never idles inside it.
    rd_go        = !wr_go && !fifo_empty;
    drain_done   = rd_go && (level_q == LW'(1));
  end

  always_comb begin
    level_mismatch = ((level_q == '0) != fifo_empty) ||
                     ((level_q == LEVEL_MAX) != fifo_full);
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    burst_cnt_nxt = burst_cnt;
    if (rd_go || fifo_empty) begin
      burst_cnt_nxt = '0;
    end else if (wr_go && (burst_cnt != BURST_MAX)) begin
      burst_cnt_nxt = burst_cnt + BW'(1);
    end
  end

  always_comb begin
    level_nxt = level_q;
    // Guards keep the counter from wrapping even if the FIFO flags misbehave.
    if (wr_go && (level_q != LEVEL_MAX)) begin
      level_nxt = level_q + LW'(1);
    end else if (rd_go && (level_q != '0)) begin
      level_nxt = level_q - LW'(1);
    end
  end

  always_comb begin
    fl_state_nxt = fl_state;
    // A held flush keeps the drain state even after the FIFO empties.
    if (flush && ((fl_state == FL_DRAIN) || !fifo_empty || wr_go)) begin
      fl_state_nxt = FL_DRAIN;
    end else if (drain_done || fifo_empty) begin
      fl_state_nxt = FL_IDLE;
    end
  end

  always_comb begin
    err_nxt = err_q || level_mismatch;
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fl_state  <= FL_IDLE;
      burst_cnt <= '0;
      level_q   <= '0;
      m_valid_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      fl_state  <= fl_state_nxt;
      burst_cnt <= burst_cnt_nxt;
      level_q   <= level_nxt;
      m_valid_q <= rd_go;
      err_q     <= err_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    m_valid     = m_valid_q;
    m_data      = m_valid_q ? fifo_data_out : '0;
    level       = level_q;
    almost_full = (level_q >= LEVEL_AF);
    flushing    = (fl_state == FL_DRAIN);
    err_level   = err_q;
  end

endmodule
